// File: rtl/zcu102_reset_request.sv
// Board reset-request generator: merges lock loss, debounced button and software requests into one held areset_out level.
// Optional cause register is compiled in with `define RESET_REQ_CAUSE_EN; without it cause reads 4'b0000.
module zcu102_reset_request #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_BITS   = 8,
  parameter int HOLD_CYCLES     = 1024,
  parameter int COOLDOWN_CYCLES = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button,
  input  logic       locked,
  input  logic       sw_req,
  output logic       sw_ack,
  output logic       areset_out,
  output logic [3:0] cause
);

  localparam int CNT_MAX = (HOLD_CYCLES > COOLDOWN_CYCLES) ? HOLD_CYCLES : COOLDOWN_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_RELEASE, COOLDOWN} state_t;

  logic [SYNC_STAGES-1:0]   btn_sync;
  logic [SYNC_STAGES-1:0]   lock_sync;
  logic [SYNC_STAGES-1:0]   primed;
  logic                     btn_s;
  logic                     lock_s;
  logic                     lock_lost;
  logic                     btn_d;
  logic [DEBOUNCE_BITS-1:0] db_cnt;
  logic                     idle_go;
  state_t                   state;
  logic [CNT_W-1:0]         cnt;

  assign btn_s  = btn_sync[SYNC_STAGES-1];
  assign lock_s = lock_sync[SYNC_STAGES-1];
  // NOTE: the lock chain powers up at 0, so its output is not trusted until a 1 has
  // walked through every stage; otherwise power-on would look like a lock loss.
  assign lock_lost = primed[SYNC_STAGES-1] & ~lock_s;
  assign idle_go   = lock_lost | btn_d | sw_req;

  // NOTE: reset is synchronous here, so it is tested inside the clocked block and
  // is not in the sensitivity list; all state uses non-blocking assignments.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_sync  <= '0;
      lock_sync <= '0;
      primed    <= '0;
    end else begin
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], button};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked};
      primed    <= {primed[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // btn_d follows btn_s only after 2^DEBOUNCE_BITS consecutive disagreeing cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_d  <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s == btn_d) begin
      db_cnt <= '0;
    end else if (&db_cnt) begin
      btn_d  <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DEBOUNCE_BITS'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ASSERT;
      cnt        <= HOLD_LOAD;
      areset_out <= 1'b1;
      sw_ack     <= 1'b0;
    end else begin
      sw_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (idle_go) begin
            state      <= ASSERT;
            areset_out <= 1'b1;
            cnt        <= HOLD_LOAD;
            sw_ack     <= sw_req;
          end
        end
        ASSERT: begin
          if (lock_lost)     cnt   <= HOLD_LOAD;
          else if (cnt == 0) state <= WAIT_RELEASE;
          else               cnt   <= cnt - CNT_W'(1);
        end
        WAIT_RELEASE: begin
          if (lock_s && !btn_d) begin
            state      <= COOLDOWN;
            areset_out <= 1'b0;
            cnt        <= COOL_LOAD;
          end
        end
        COOLDOWN: begin
          // Lock loss is never masked by the cooldown window.
          if (lock_lost) begin
            state      <= ASSERT;
            areset_out <= 1'b1;
            cnt        <= HOLD_LOAD;
          end else if (cnt == 0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

`ifdef RESET_REQ_CAUSE_EN
  logic [3:0] cause_q;

  always_ff @(posedge clock) begin
    if (reset)                              cause_q    <= 4'b0001;
    else if (state == IDLE && idle_go)      cause_q    <= {sw_req, btn_d, lock_lost, 1'b0};
    else if (state == ASSERT && lock_lost)  cause_q[1] <= 1'b1;
    else if (state == COOLDOWN && lock_lost) cause_q   <= 4'b0010;
  end

  assign cause = cause_q;
`else
  assign cause = 4'b0000;
`endif

endmodule

// File: tb/tb_zcu102_reset_request.sv
// Self-checking bench for zcu102_reset_request: scenario table plus hand sequences,
// each reset event scored when areset_out falls.
module tb_zcu102_reset_request;

  logic       clock;
  logic       reset;
  logic       button;
  logic       locked;
  logic       sw_req;
  logic       sw_ack;
  logic       areset_out;
  logic [3:0] cause;

  zcu102_reset_request #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_BITS  (3),
    .HOLD_CYCLES    (16),
    .COOLDOWN_CYCLES(8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .button    (button),
    .locked    (locked),
    .sw_req    (sw_req),
    .sw_ack    (sw_ack),
    .areset_out(areset_out),
    .cause     (cause)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         start;
    int         delay;
    int         high;
    logic [3:0] cause;
    int         acks;
  } exp_t;

  typedef enum {SC_SW, SC_LOCK, SC_BTN, SC_BOTH, SC_LOCK5, SC_BOUNCE} sc_e;

  typedef struct {
    sc_e        kind;
    int         delay;
    int         high;
    logic [3:0] cause;
    int         acks;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  int   cyc      = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   ack_cnt  = 0;
  int   rise_cyc = 0;
  logic prev_are = 1'b1;
  logic mon_en   = 1'b0;

  function automatic logic [3:0] ec(input logic [3:0] c);
`ifdef RESET_REQ_CAUSE_EN
    return c;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int start, input int delay, input int high,
                      input logic [3:0] c, input int acks);
    exp_t e;
    e.start = start;
    e.delay = delay;
    e.high  = high;
    e.cause = c;
    e.acks  = acks;
    sb.push_back(e);
  endtask

  task automatic retire();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: areset_out fell at cycle %0d, expected no event", cyc);
    end else begin
      e = sb.pop_front();
      if (e.delay >= 0) check("rise_delay", rise_cyc - e.start, e.delay);
      check("high_cycles", cyc - rise_cyc, e.high);
      check("cause", cause, ec(e.cause));
      check("ack_count", ack_cnt, e.acks);
    end
    ack_cnt = 0;
  endtask

  // Advance one clock and sample 1 ns after the edge; the event monitor lives here.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (mon_en) begin
      if (sw_ack) ack_cnt++;
      if (areset_out && !prev_are) rise_cyc = cyc;
      if (!areset_out && prev_are) retire();
      prev_are = areset_out;
    end
  endtask

  task automatic wait_ack(input int limit);
    for (int i = 0; i < limit; i++) begin
      step();
      if (sw_ack) break;
    end
    check("ack_seen", sw_ack, 1);
    check("ack_on_rise", rise_cyc, cyc);
    sw_req = 1'b0;
    step();
    check("ack_one_pulse", sw_ack, 0);
  endtask

  task automatic wait_fall(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!areset_out) break;
      step();
    end
    check("fall_seen", areset_out, 0);
  endtask

  task automatic wait_idle();
    int lows = 0;
    for (int i = 0; i < 300 && lows < 12; i++) begin
      step();
      lows = areset_out ? 0 : lows + 1;
    end
    check("idle_reached", lows, 12);
  endtask

  task automatic run_vec(input vec_t v);
    int   c0;
    logic any_high;
    c0 = cyc;
    if (v.kind != SC_BOUNCE) push(c0, v.delay, v.high, v.cause, v.acks);
    case (v.kind)
      SC_SW: begin
        sw_req = 1'b1;
        wait_ack(40);
      end
      SC_LOCK: begin
        locked = 1'b0;
        step();
        locked = 1'b1;
      end
      SC_BTN: begin
        button = 1'b1;
        repeat (20) step();
        button = 1'b0;
      end
      SC_BOTH: begin
        locked = 1'b0;
        step();
        locked = 1'b1;
        step();
        sw_req = 1'b1;
        wait_ack(40);
      end
      SC_LOCK5: begin
        sw_req = 1'b1;
        wait_ack(40);
        while (cyc < c0 + 11) step();
        locked = 1'b0;
        step();
        locked = 1'b1;
      end
      SC_BOUNCE: begin
        any_high = 1'b0;
        for (int i = 0; i < 30; i++) begin
          button = ((i / 3) % 2) == 0;
          step();
          any_high |= areset_out;
        end
        button = 1'b0;
        repeat (12) begin
          step();
          any_high |= areset_out;
        end
        check("bounce_no_reset", any_high, 0);
      end
      default: ;
    endcase
  endtask

  initial begin
    int c0;
    int f;

    vecs[0] = '{kind: SC_SW,     delay: 1,  high: 17, cause: 4'b1000, acks: 1};
    vecs[1] = '{kind: SC_LOCK,   delay: 3,  high: 17, cause: 4'b0010, acks: 0};
    vecs[2] = '{kind: SC_BTN,    delay: 11, high: 20, cause: 4'b0100, acks: 0};
    vecs[3] = '{kind: SC_BOTH,   delay: 3,  high: 17, cause: 4'b1010, acks: 1};
    vecs[4] = '{kind: SC_LOCK5,  delay: 1,  high: 30, cause: 4'b1010, acks: 1};
    vecs[5] = '{kind: SC_BOUNCE, delay: -1, high: 0,  cause: 4'b0000, acks: 0};

    reset  = 1'b1;
    button = 1'b0;
    locked = 1'b1;
    sw_req = 1'b0;
    push(0, -1, 17, 4'b0001, 0);
    step();
    check("por_areset", areset_out, 1);
    check("por_sw_ack", sw_ack, 0);
    check("por_cause", cause, ec(4'b0001));
    rise_cyc = cyc;
    prev_are = 1'b1;
    mon_en   = 1'b1;
    reset    = 1'b0;

    for (int i = 0; i < 6; i++) begin
      wait_idle();
      run_vec(vecs[i]);
    end

    // Request raised during cooldown stays pending and is acked on the first IDLE edge.
    wait_idle();
    push(cyc, 1, 17, 4'b1000, 1);
    sw_req = 1'b1;
    wait_ack(40);
    wait_fall(60);
    f = cyc;
    step();
    step();
    push(cyc, 7, 17, 4'b1000, 1);
    sw_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (sw_ack) break;
    end
    check("cool_ack_cycle", cyc, f + 9);
    sw_req = 1'b0;
    step();
    check("cool_ack_one_pulse", sw_ack, 0);

    // Lock loss inside cooldown re-enters ASSERT at once with cause 0010.
    wait_fall(60);
    step();
    push(cyc, 3, 17, 4'b0010, 0);
    locked = 1'b0;
    step();
    locked = 1'b1;

    // sw_req during ASSERT neither extends the hold nor gets acked until IDLE.
    wait_idle();
    c0 = cyc;
    push(c0, 11, 20, 4'b0100, 0);
    button = 1'b1;
    repeat (15) step();
    push(cyc, 25, 17, 4'b1000, 1);
    sw_req = 1'b1;
    repeat (5) step();
    button = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (sw_ack) break;
    end
    check("pending_ack_cycle", cyc, c0 + 40);
    sw_req = 1'b0;

    // Synchronous reset while held in WAIT_RELEASE restarts a full power-on hold.
    wait_idle();
    c0 = cyc;
    push(c0, 11, 37, 4'b0001, 0);
    button = 1'b1;
    repeat (30) step();
    check("wait_held", areset_out, 1);
    reset  = 1'b1;
    button = 1'b0;
    step();
    check("rst_mid_areset", areset_out, 1);
    check("rst_mid_sw_ack", sw_ack, 0);
    check("rst_mid_cause", cause, ec(4'b0001));
    reset = 1'b0;

    wait_idle();
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
